neopixel_frame_ctrl: RTL and testbench
======================================

// Module: neopixel_frame_ctrl
// PURPOSE
//   Double-buffered frame controller for the neopixel string driver.
//   - Accepts byte writes from a host into a back buffer.
//   - On a commit request, copies the back buffer to the front buffer (framebuf).
//   - Releases the driver from reset for exactly one frame, then parks it.
//   - The driver therefore never sees framebuf change mid-frame.
// PARAMETERS
//   NUM_BYTES      48    bytes of LED data (16 RGB LEDs); framebuf = 8*NUM_BYTES bits
//   FRAME_CYCLES   500   clk cycles drv_nrst is held high per frame (sync + data)
//   REFRESH_CYCLES 8000  idle cycles before an autonomous refresh (AUTOREFRESH only)
// PORTS
//   clk         in   1              800kHz clock, shared with the driver
//   nrst        in   1              synchronous reset, active low
//   wr_en       in   1              host byte write strobe
//   wr_addr     in   6              byte index; byte a occupies bits [8a+7:8a]
//   wr_data     in   8              byte value
//   wr_err      out  1              1-cycle pulse: write to wr_addr >= NUM_BYTES
//   commit_req  in   1              pulse: request publish of back buffer
//   commit_ack  out  1              1-cycle pulse: back buffer copied to front
//   busy        out  1              high in SWAP and RUN
//   frame_done  out  1              1-cycle pulse on RUN -> IDLE
//   drv_nrst    out  1              reset to driver; high only in RUN
//   framebuf    out  8*NUM_BYTES    front buffer, to driver framebuf input
// BEHAVIOUR
//   Reset (nrst=0 at posedge): state IDLE; back and front buffers 0.
//     - All outputs 0: wr_err, commit_ack, busy, frame_done, drv_nrst, framebuf.
//     - pending flag and all counters cleared.
//   Reset mid-RUN: drv_nrst low on that edge; no frame_done; pending commit dropped, no ack.
//   Writes (any state): wr_en and wr_addr < NUM_BYTES -> byte updated at next edge.
//     - Address out of range: ignored; wr_err=1 for the following cycle.
//     - Never affects framebuf directly.
//   pending: set by commit_req in any state; cleared in the SWAP cycle.
//     - Multiple requests before service coalesce into one ack.
//   FSM:
//     - IDLE: drv_nrst=0, busy=0. If pending or commit_req -> SWAP.
//     - SWAP (1 cycle): front <= back (pre-edge value); commit_ack=1, busy=1.
//         A write in this cycle lands in the back buffer only. Next state RUN.
//     - RUN: drv_nrst=1, busy=1; cnt counts 0..FRAME_CYCLES-1.
//         At cnt==FRAME_CYCLES-1 -> IDLE; frame_done=1 in the first IDLE cycle.
//         framebuf constant throughout RUN.
//   Latency: commit_req in IDLE at edge N.
//     - commit_ack and copy at N+1.
//     - drv_nrst high N+2 .. N+1+FRAME_CYCLES.
//   Commit during RUN: remembered. SWAP follows the first IDLE cycle, giving the
//     driver at least one low-reset cycle between frames.
//   Counters sized $clog2 of their limit; cnt holds 0 outside RUN.
// CONFIGURATION
//   NEOPIXEL_CTRL_AUTOREFRESH_EN defined:
//     - idle_cnt increments each IDLE cycle without pending; cleared elsewhere.
//     - At idle_cnt==REFRESH_CYCLES-1 -> RUN directly: no copy, no commit_ack.
//     - Commit wins if both occur in the same cycle.
//   Undefined: no idle_cnt; controller stays in IDLE until a commit.
// TESTING
//   1. Reset: nrst=0 3 cycles -> all outputs 0, framebuf==0.
//   2. Write 0xAA@0, 0x55@47, commit -> ack next cycle.
//        framebuf[7:0]=AA, [383:376]=55; drv_nrst high exactly 500 cycles; frame_done once.
//   3. wr_addr=48 -> wr_err pulse, buffers unchanged. Commit during RUN (twice)
//        -> one ack after 1 IDLE cycle.
//   4. Write byte 3 during RUN -> framebuf unchanged until next commit's SWAP.
//   5. nrst low at RUN cycle 100 -> drv_nrst 0 next edge, no frame_done, no later ack.
//   6. AUTOREFRESH_EN, no commits -> RUN entered after 8000 idle cycles, no ack,
//        framebuf unchanged; commit at cycle 7999 -> SWAP taken instead.

Source files
------------

// File: rtl/neopixel_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// neopixel_frame_ctrl_if
//   Host/driver-side bundle for the neopixel frame controller.
//
//   Signals
//     wr_en, wr_addr, wr_data : host byte write into the back buffer
//     wr_err                  : 1-cycle pulse after an out-of-range write
//     commit_req              : request to publish the back buffer
//     commit_ack              : 1-cycle pulse while the back->front copy happens
//     busy                    : controller is swapping or running a frame
//     frame_done              : 1-cycle pulse after a frame completes
//     drv_nrst                : reset to the string driver, high only while running
//     framebuf                : front buffer presented to the driver
//
//   Modports
//     master : host side (drives writes and commits)
//     slave  : controller side
// ---------------------------------------------------------------------------
interface neopixel_frame_ctrl_if #(
  parameter int NUM_BYTES = 48
);
  logic                   wr_en;
  logic [5:0]             wr_addr;
  logic [7:0]             wr_data;
  logic                   wr_err;
  logic                   commit_req;
  logic                   commit_ack;
  logic                   busy;
  logic                   frame_done;
  logic                   drv_nrst;
  logic [8*NUM_BYTES-1:0] framebuf;

  modport master (
    output wr_en, wr_addr, wr_data, commit_req,
    input  wr_err, commit_ack, busy, frame_done, drv_nrst, framebuf
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit_req,
    output wr_err, commit_ack, busy, frame_done, drv_nrst, framebuf
  );
endinterface

// File: rtl/neopixel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// neopixel_frame_ctrl
//   Double-buffered frame controller for the neopixel string driver. The host
//   writes bytes into a back buffer at any time; a commit copies the back
//   buffer into the front buffer (framebuf) and then releases the driver from
//   reset for exactly one frame. framebuf never changes while the driver runs.
//
//   Ports
//     i_clk  : clock shared with the driver
//     i_nrst : synchronous reset, active low
//     bus    : neopixel_frame_ctrl_if.slave (writes, commit handshake, status,
//              driver reset and front buffer)
//
//   Parameters
//     NUM_BYTES      : bytes of LED data (framebuf is 8*NUM_BYTES bits)
//     FRAME_CYCLES   : cycles drv_nrst stays high per frame
//     REFRESH_CYCLES : idle cycles before an autonomous refresh
//                      (only with NEOPIXEL_CTRL_AUTOREFRESH_EN)
//
//   Build option
//     NEOPIXEL_CTRL_AUTOREFRESH_EN : when defined, a long idle period starts a
//     frame on its own (no copy, no commit_ack). Undefined, the controller
//     waits in IDLE for a commit.
// ---------------------------------------------------------------------------
module neopixel_frame_ctrl #(
  parameter int NUM_BYTES    = 48,
  parameter int FRAME_CYCLES = 500
`ifdef NEOPIXEL_CTRL_AUTOREFRESH_EN
  , parameter int REFRESH_CYCLES = 8000
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  neopixel_frame_ctrl_if.slave  bus
);

  localparam int                 CNT_W      = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_CYCLES - 1);
  // One bit wider than the address so 48..63 compare cleanly.
  localparam logic [6:0]         BYTE_LIMIT = 7'(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SWAP = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [8*NUM_BYTES-1:0]  r_backBuf;
  logic [8*NUM_BYTES-1:0]  r_frontBuf;
  logic                    r_pending;
  logic                    r_wrErr;
  logic                    r_frameDone;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_wrValid;
  logic                    w_frameEnd;
  logic                    w_autoRefresh;
  logic                    w_commitAck;
  logic                    w_busy;
  logic                    w_drvNrst;

  assign w_wrValid  = bus.wr_en && ({1'b0, bus.wr_addr} < BYTE_LIMIT);
  assign w_frameEnd = (r_state == RUN) && (r_cnt == CNT_LAST);

`ifdef NEOPIXEL_CTRL_AUTOREFRESH_EN
  localparam int                IDLE_W    = $clog2(REFRESH_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(REFRESH_CYCLES - 1);

  logic [IDLE_W-1:0] r_idleCnt;

  assign w_autoRefresh = (r_state == IDLE) && !r_pending && (r_idleCnt == IDLE_LAST);

  // Idle timer: runs only while nothing is waiting to be published, and
  // restarts from zero whenever the controller leaves IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_idleCnt <= '0;
    end else if ((r_state == IDLE) && !r_pending && !w_autoRefresh) begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end else begin
      r_idleCnt <= '0;
    end
  end
`else
  assign w_autoRefresh = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A commit (new or remembered) outranks an autonomous
  // refresh, and a commit seen during RUN is only serviced from IDLE so the
  // driver always gets at least one low-reset cycle between frames.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (r_pending || bus.commit_req) begin
          w_nextState = SWAP;
        end else if (w_autoRefresh) begin
          w_nextState = RUN;
        end
      end
      SWAP: w_nextState = RUN;
      RUN: begin
        if (w_frameEnd) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    w_commitAck = 1'b0;
    w_busy      = 1'b0;
    w_drvNrst   = 1'b0;
    case (r_state)
      SWAP: begin
        w_commitAck = 1'b1;
        w_busy      = 1'b1;
      end
      RUN: begin
        w_busy    = 1'b1;
        w_drvNrst = 1'b1;
      end
      default: ;
    endcase
  end

  // Pending commit flag. A request arriving in the SWAP cycle itself is kept,
  // since the copy being made uses the buffer contents from before it.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_pending <= 1'b0;
    end else if (bus.commit_req) begin
      r_pending <= 1'b1;
    end else if (r_state == SWAP) begin
      r_pending <= 1'b0;
    end
  end

  // Frame cycle counter; parked at zero outside RUN.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_cnt <= '0;
    end else if ((r_state == RUN) && !w_frameEnd) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_wrErr     <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_wrErr     <= bus.wr_en && !w_wrValid;
      r_frameDone <= w_frameEnd;
    end
  end

  // Back and front buffers. The copy in SWAP takes the back buffer as it was
  // before this edge, so a same-cycle write only reaches the back buffer.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_backBuf  <= '0;
      r_frontBuf <= '0;
    end else begin
      if (w_wrValid) begin
        r_backBuf[{bus.wr_addr, 3'b000} +: 8] <= bus.wr_data;
      end
      if (r_state == SWAP) begin
        r_frontBuf <= r_backBuf;
      end
    end
  end

  assign bus.wr_err     = r_wrErr;
  assign bus.commit_ack = w_commitAck;
  assign bus.busy       = w_busy;
  assign bus.frame_done = r_frameDone;
  assign bus.drv_nrst   = w_drvNrst;
  assign bus.framebuf   = r_frontBuf;

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_neopixel_frame_ctrl
//   Self-checking bench for neopixel_frame_ctrl (default parameters). Keeps a
//   reference back/front buffer, a queue of expected front-buffer contents
//   for each copy, and checks reset, writes, commits, frame timing and reset
//   during a frame. With NEOPIXEL_CTRL_AUTOREFRESH_EN defined it also checks
//   the autonomous refresh; otherwise it checks that no refresh happens.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_neopixel_frame_ctrl;

  localparam int NB = 48;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    logic       expErr;
  } wrVec_t;

  logic clk = 1'b0;
  logic nrst;

  int checks = 0;
  int errors = 0;
  int ackCount = 0;
  logic ackPrev = 1'b0;

  logic [8*NB-1:0] mBack  = '0;
  logic [8*NB-1:0] mFront = '0;
  logic [8*NB-1:0] expQ[$];

  always #5 clk = ~clk;

  neopixel_frame_ctrl_if #(.NUM_BYTES(NB)) bus ();

  neopixel_frame_ctrl dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  task automatic checkOutput(input string name, input logic [8*NB-1:0] act,
                             input logic [8*NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one host write and mirrors it into the reference back buffer.
  task automatic applyStimulus(input logic [5:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    if (int'(a) < NB) mBack[8*int'(a) +: 8] = d;
  endtask

  // Commit from IDLE; the ack must follow on the next cycle.
  task automatic doCommit();
    @(negedge clk);
    bus.wr_en      = 1'b0;
    bus.commit_req = 1'b1;
    expQ.push_back(mBack);
    mFront = mBack;
    @(negedge clk);
    bus.commit_req = 1'b0;
    checkOutput("commit_ack", bus.commit_ack, 1);
    checkOutput("busy_swap", bus.busy, 1);
    checkOutput("drv_nrst_swap", bus.drv_nrst, 0);
  endtask

  // Follows one frame up to the frame_done cycle, optionally writing and
  // committing at given RUN cycle indexes (-1 = never).
  task automatic runFrame(input int expHigh, input int wrAt, input logic [5:0] wrA,
                          input logic [7:0] wrD, input int c1, input int c2,
                          output logic gotCommit);
    int highCnt;
    int doneCnt;
    logic changed;
    logic [8*NB-1:0] startFb;
    highCnt = 0; doneCnt = 0; changed = 1'b0; startFb = mFront; gotCommit = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.commit_req = 1'b0;
      if (bus.frame_done === 1'b1) begin
        doneCnt++;
        break;
      end
      if (bus.drv_nrst === 1'b1) begin
        if (bus.framebuf !== startFb) changed = 1'b1;
        if (highCnt == wrAt) applyStimulus(wrA, wrD);
        if (highCnt == c1 || highCnt == c2) begin
          bus.commit_req = 1'b1;
          gotCommit = 1'b1;
        end
        highCnt++;
      end
    end
    bus.wr_en = 1'b0;
    bus.commit_req = 1'b0;
    checkOutput("run_cycles", highCnt, expHigh);
    checkOutput("frame_done_seen", doneCnt, 1);
    checkOutput("framebuf_stable_in_run", changed, 0);
    checkOutput("drv_nrst_at_done", bus.drv_nrst, 0);
    checkOutput("busy_at_done", bus.busy, 0);
    if (gotCommit) begin
      expQ.push_back(mBack);
      mFront = mBack;
    end
  endtask

  // Scoreboard: one cycle after each ack the copy must have landed.
  always @(negedge clk) begin
    if (ackPrev) begin
      if (expQ.size() == 0) checkOutput("unexpected_ack", 1, 0);
      else checkOutput("swap_framebuf", bus.framebuf, expQ.pop_front());
    end
    ackPrev = (bus.commit_ack === 1'b1);
    if (bus.commit_ack === 1'b1) ackCount++;
  end

  initial begin
    wrVec_t vecs[7];
    logic got;
    int runIdx;
    int dones;
    int baseAck;
    int idle;
    logic seen;

    vecs[0] = '{6'd0,  8'hAA, 1'b0};
    vecs[1] = '{6'd47, 8'h55, 1'b0};
    vecs[2] = '{6'd48, 8'h12, 1'b1};
    vecs[3] = '{6'd63, 8'h34, 1'b1};
    vecs[4] = '{6'd10, 8'h81, 1'b0};
    vecs[5] = '{6'd20, 8'h0F, 1'b0};
    vecs[6] = '{6'd49, 8'hFF, 1'b1};

    nrst = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.commit_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_err", bus.wr_err, 0);
    checkOutput("rst_commit_ack", bus.commit_ack, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_frame_done", bus.frame_done, 0);
    checkOutput("rst_drv_nrst", bus.drv_nrst, 0);
    checkOutput("rst_framebuf", bus.framebuf, 0);
    nrst = 1'b1;

    // Write table, including out-of-range addresses
    foreach (vecs[i]) begin
      @(negedge clk);
      checkOutput("wr_err_idle", bus.wr_err, 0);
      applyStimulus(vecs[i].addr, vecs[i].data);
      @(negedge clk);
      bus.wr_en = 1'b0;
      checkOutput("wr_err", bus.wr_err, vecs[i].expErr);
    end

    // Commit from IDLE and one full frame
    doCommit();
    runFrame(500, -1, 6'd0, 8'h00, -1, -1, got);
    checkOutput("fb_byte0", bus.framebuf[7:0], 8'hAA);
    checkOutput("fb_byte47", bus.framebuf[383:376], 8'h55);
    @(negedge clk);
    checkOutput("frame_done_pulse", bus.frame_done, 0);
    checkOutput("no_ack_after_frame", bus.commit_ack, 0);

    // Two commits and a write during RUN: framebuf frozen, one ack after one IDLE cycle
    doCommit();
    runFrame(500, 5, 6'd3, 8'hC3, 10, 20, got);
    checkOutput("ack_not_in_gap", bus.commit_ack, 0);
    @(negedge clk);
    checkOutput("pending_ack", bus.commit_ack, 1);
    checkOutput("pending_drv_nrst", bus.drv_nrst, 0);
    runFrame(500, -1, 6'd0, 8'h00, -1, -1, got);
    checkOutput("fb_byte3", bus.framebuf[31:24], 8'hC3);
    checkOutput("coalesced_acks", ackCount, 3);

`ifdef NEOPIXEL_CTRL_AUTOREFRESH_EN
    // Autonomous refresh after a long idle period: no ack, no copy
    baseAck = ackCount;
    idle = 0;
    for (int k = 0; k < 9000; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.drv_nrst === 1'b1) break;
      idle++;
    end
    checkOutput("refresh_idle_cycles", idle, 8000);
    runFrame(499, -1, 6'd0, 8'h00, -1, -1, got);
    checkOutput("refresh_no_ack", ackCount - baseAck, 0);
    checkOutput("refresh_framebuf", bus.framebuf, mFront);

    // Commit on the last idle cycle wins over the refresh
    seen = 1'b0;
    for (int k = 0; k < 8000; k++) begin
      if (k > 0) @(negedge clk);
      bus.wr_en = 1'b0;
      if (bus.drv_nrst === 1'b1) seen = 1'b1;
      if (k == 100) applyStimulus(6'd5, 8'h77);
      if (k == 7999) begin
        bus.commit_req = 1'b1;
        expQ.push_back(mBack);
        mFront = mBack;
      end
    end
    @(negedge clk);
    bus.commit_req = 1'b0;
    checkOutput("early_refresh", seen, 0);
    checkOutput("late_commit_ack", bus.commit_ack, 1);
    checkOutput("late_commit_swap", bus.drv_nrst, 0);
    runFrame(500, -1, 6'd0, 8'h00, -1, -1, got);
`else
    // Without the refresh option the controller must sit in IDLE
    seen = 1'b0;
    for (int k = 0; k < 9000; k++) begin
      @(negedge clk);
      if (bus.drv_nrst !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    checkOutput("no_autorefresh", seen, 0);
`endif

    // Reset in the middle of a frame drops the frame and the pending commit
    @(negedge clk);
    applyStimulus(6'd7, 8'h99);
    doCommit();
    runIdx = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      bus.commit_req = 1'b0;
      if (bus.drv_nrst === 1'b1) begin
        if (runIdx == 50) bus.commit_req = 1'b1;
        if (runIdx == 100) begin
          nrst = 1'b0;
          break;
        end
        runIdx++;
      end
    end
    checkOutput("reached_run_100", runIdx, 100);
    @(negedge clk);
    checkOutput("midrun_drv_nrst", bus.drv_nrst, 0);
    checkOutput("midrun_busy", bus.busy, 0);
    checkOutput("midrun_frame_done", bus.frame_done, 0);
    checkOutput("midrun_framebuf", bus.framebuf, 0);
    nrst = 1'b1;
    mBack = '0;
    mFront = '0;
    baseAck = ackCount;
    dones = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) dones++;
    end
    checkOutput("post_reset_frame_done", dones, 0);
    checkOutput("post_reset_ack", ackCount - baseAck, 0);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
